// File: rtl/instrumented_adder_pkg.sv
// Shared types and constants for the instrumented adder sweep controller.
package instrumented_adder_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_CNT_W      = 32;
  localparam int RUN_TIMEOUT_MARGIN = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE,
    ST_REPORT
  } state_t;

endpackage

// File: rtl/sweep_bit_picker.sv
// Finds the lowest set mask bit: from bit 0 when i_first, else strictly above i_cur.
module sweep_bit_picker
  import instrumented_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_mask,
  input  logic [IDX_W-1:0] i_cur,
  input  logic             i_first,
  output logic [IDX_W-1:0] o_next,
  output logic             o_found
);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    o_next  = '0;
    o_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i > int'(i_cur)))) begin
        o_next  = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instrumented_adder_sweep_ctrl.sv
// Sweeps an instrumented adder's ring oscillator over each selected bit and reports counts.
// Define SWEEP_TIMEOUT_EN to add a RUN watchdog (integration_time + margin cycles).
module instrumented_adder_sweep_ctrl
  import instrumented_adder_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int CNT_W         = DEFAULT_CNT_W,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     reset_b,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         bit_mask,
  input  logic [CNT_W-1:0]         integration_time,
  input  logic                     done,
  input  logic [CNT_W-1:0]         ring_osc_counter_out,
  output logic                     adder_reset,
  output logic                     stop_b,
  output logic                     counter_enable,
  output logic                     counter_load,
  output logic [WIDTH-1:0]         ring_bit_b,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [$clog2(WIDTH)-1:0] result_bit,
  output logic [CNT_W-1:0]         result_count,
  output logic                     result_timeout,
  output logic                     busy,
  output logic                     sweep_done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mask;
  logic [IDX_W-1:0]   r_cur;
  logic [SET_W-1:0]   r_settle_cnt;
  logic               r_adder_reset;
  logic               r_stop_b;
  logic               r_counter_enable;
  logic               r_counter_load;
  logic [WIDTH-1:0]   r_ring_bit_b;
  logic               r_result_valid;
  logic [IDX_W-1:0]   r_result_bit;
  logic [CNT_W-1:0]   r_result_count;
  logic               r_sweep_done;

  logic [WIDTH-1:0]   w_pick_mask;
  logic               w_first;
  logic [IDX_W-1:0]   w_next;
  logic               w_found;

  // One picker serves both the initial search (live input mask) and the advance (latched mask).
  assign w_first     = (r_state == ST_IDLE);
  assign w_pick_mask = w_first ? bit_mask : r_mask;

  sweep_bit_picker #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_mask  (w_pick_mask),
    .i_cur   (r_cur),
    .i_first (w_first),
    .o_next  (w_next),
    .o_found (w_found)
  );

`ifdef SWEEP_TIMEOUT_EN
  logic [CNT_W-1:0] r_int_time;
  logic [CNT_W:0]   r_run_cnt;
  logic [CNT_W:0]   w_run_last;
  logic             r_result_timeout;

  assign w_run_last     = {1'b0, r_int_time} + (CNT_W+1)'(RUN_TIMEOUT_MARGIN - 1);
  assign result_timeout = r_result_timeout;
`else
  logic w_unused_int_time;

  assign w_unused_int_time = ^integration_time;
  assign result_timeout    = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!reset_b) begin
      r_state          <= ST_IDLE;
      r_mask           <= '0;
      r_cur            <= '0;
      r_settle_cnt     <= '0;
      r_adder_reset    <= 1'b1;
      r_stop_b         <= 1'b0;
      r_counter_enable <= 1'b0;
      r_counter_load   <= 1'b0;
      r_ring_bit_b     <= '1;
      r_result_valid   <= 1'b0;
      r_result_bit     <= '0;
      r_result_count   <= '0;
      r_sweep_done     <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
      r_int_time       <= '0;
      r_run_cnt        <= '0;
      r_result_timeout <= 1'b0;
`endif
    end else begin
      r_sweep_done <= 1'b0;
      if (abort) begin
        r_state          <= ST_IDLE;
        r_adder_reset    <= 1'b1;
        r_stop_b         <= 1'b0;
        r_counter_enable <= 1'b0;
        r_counter_load   <= 1'b0;
        r_ring_bit_b     <= '1;
        r_result_valid   <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
        r_result_timeout <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_mask <= bit_mask;
`ifdef SWEEP_TIMEOUT_EN
              r_int_time <= integration_time;
`endif
              if (w_found) begin
                r_cur         <= w_next;
                r_ring_bit_b  <= ~(WIDTH'(1) << w_next);
                r_adder_reset <= 1'b1;
                r_state       <= ST_SELECT;
              end else begin
                r_sweep_done <= 1'b1;
              end
            end
          end
          ST_SELECT: begin
            r_adder_reset <= 1'b0;
            r_settle_cnt  <= '0;
            r_state       <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
              r_counter_load <= 1'b1;
              r_state        <= ST_LOAD;
            end else begin
              r_settle_cnt <= r_settle_cnt + SET_W'(1);
            end
          end
          ST_LOAD: begin
            r_counter_load   <= 1'b0;
            r_stop_b         <= 1'b1;
            r_counter_enable <= 1'b1;
`ifdef SWEEP_TIMEOUT_EN
            r_run_cnt        <= '0;
`endif
            r_state          <= ST_RUN;
          end
          ST_RUN: begin
            if (done) begin
              r_stop_b         <= 1'b0;
              r_counter_enable <= 1'b0;
              r_state          <= ST_CAPTURE;
            end
`ifdef SWEEP_TIMEOUT_EN
            else if (r_run_cnt == w_run_last) begin
              r_stop_b         <= 1'b0;
              r_counter_enable <= 1'b0;
              r_result_timeout <= 1'b1;
              r_state          <= ST_CAPTURE;
            end else begin
              r_run_cnt <= r_run_cnt + (CNT_W+1)'(1);
            end
`endif
          end
          ST_CAPTURE: begin
            r_result_count <= ring_osc_counter_out;
            r_result_bit   <= r_cur;
            r_result_valid <= 1'b1;
            r_state        <= ST_REPORT;
          end
          ST_REPORT: begin
            if (result_ready) begin
              r_result_valid <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
              r_result_timeout <= 1'b0;
`endif
              r_adder_reset  <= 1'b1;
              if (w_found) begin
                r_cur        <= w_next;
                r_ring_bit_b <= ~(WIDTH'(1) << w_next);
                r_state      <= ST_SELECT;
              end else begin
                r_ring_bit_b <= '1;
                r_sweep_done <= 1'b1;
                r_state      <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign adder_reset    = r_adder_reset;
  assign stop_b         = r_stop_b;
  assign counter_enable = r_counter_enable;
  assign counter_load   = r_counter_load;
  assign ring_bit_b     = r_ring_bit_b;
  assign result_valid   = r_result_valid;
  assign result_bit     = r_result_bit;
  assign result_count   = r_result_count;
  assign sweep_done     = r_sweep_done;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_instrumented_adder_sweep_ctrl.sv
// Scoreboard bench: stimulus queues expected results/sweep_done events, a monitor checks them.
`timescale 1ns/1ps
module tb_instrumented_adder_sweep_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 32;

  logic             wb_clk_i = 1'b0;
  logic             reset_b;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] bit_mask;
  logic [CNT_W-1:0] integration_time;
  logic             done;
  logic [CNT_W-1:0] ring_osc_counter_out;
  logic             adder_reset;
  logic             stop_b;
  logic             counter_enable;
  logic             counter_load;
  logic [WIDTH-1:0] ring_bit_b;
  logic             result_valid;
  logic             result_ready;
  logic [2:0]       result_bit;
  logic [CNT_W-1:0] result_count;
  logic             result_timeout;
  logic             busy;
  logic             sweep_done;

  always #5 wb_clk_i = ~wb_clk_i;

  instrumented_adder_sweep_ctrl #(
    .WIDTH         (WIDTH),
    .CNT_W         (CNT_W),
    .SETTLE_CYCLES (4)
  ) dut (
    .wb_clk_i             (wb_clk_i),
    .reset_b              (reset_b),
    .start                (start),
    .abort                (abort),
    .bit_mask             (bit_mask),
    .integration_time     (integration_time),
    .done                 (done),
    .ring_osc_counter_out (ring_osc_counter_out),
    .adder_reset          (adder_reset),
    .stop_b               (stop_b),
    .counter_enable       (counter_enable),
    .counter_load         (counter_load),
    .ring_bit_b           (ring_bit_b),
    .result_valid         (result_valid),
    .result_ready         (result_ready),
    .result_bit           (result_bit),
    .result_count         (result_count),
    .result_timeout       (result_timeout),
    .busy                 (busy),
    .sweep_done           (sweep_done)
  );

  typedef struct {
    bit          is_done;
    logic [2:0]  bitn;
    logic [31:0] cnt;
    logic        tmo;
    logic [7:0]  ring;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  logic        mon_prev_valid = 1'b0;
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] bit_count [WIDTH];
  int          latency = 0;
  int          model_remaining = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string what);
    n_vec++;
    n_miss++;
    $display("FAIL unexpected_%s: got a DUT %s event, expected none queued", what, what);
  endfunction

  function automatic void push_res(input logic [2:0] b, input logic [31:0] c, input logic t,
                                   input logic [7:0] r);
    ev_t e;
    e.is_done = 1'b0;
    e.bitn    = b;
    e.cnt     = c;
    e.tmo     = t;
    e.ring    = r;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done();
    ev_t e;
    e.is_done = 1'b1;
    e.bitn    = '0;
    e.cnt     = '0;
    e.tmo     = 1'b0;
    e.ring    = '1;
    exp_q.push_back(e);
  endfunction

  function automatic int ring_idx(input logic [7:0] r);
    int idx = 0;
    for (int i = 0; i < WIDTH; i++) if (!r[i]) idx = i;
    return idx;
  endfunction

  // Adder model: count loaded on counter_load, done pulses 'latency' RUN cycles later (0 = never).
  initial begin : adder_model
    done = 1'b0;
    ring_osc_counter_out = '0;
    forever begin
      @(negedge wb_clk_i);
      if (reset_b !== 1'b1 || adder_reset === 1'b1) begin
        model_remaining = 0;
        done = 1'b0;
      end else begin
        done = 1'b0;
        if (counter_load === 1'b1) begin
          model_remaining = latency;
          ring_osc_counter_out = bit_count[ring_idx(ring_bit_b)];
        end else if (model_remaining > 0) begin
          model_remaining--;
          if (model_remaining == 0) done = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge wb_clk_i);
      if (result_valid === 1'b1 && mon_prev_valid == 1'b0) begin
        if (exp_q.size() == 0) unexpected("result");
        else begin
          mon_e = exp_q.pop_front();
          check("event_kind_result", 64'(mon_e.is_done), 64'(0));
          check("result_bit", 64'(result_bit), 64'(mon_e.bitn));
          check("result_count", 64'(result_count), 64'(mon_e.cnt));
          check("result_timeout", 64'(result_timeout), 64'(mon_e.tmo));
          check("ring_bit_b", 64'(ring_bit_b), 64'(mon_e.ring));
          $display("result: bit %0d count 0x%0h timeout %0b ring 0x%0h", result_bit, result_count,
                   result_timeout, ring_bit_b);
        end
      end
      if (sweep_done === 1'b1) begin
        if (exp_q.size() == 0) unexpected("sweep_done");
        else begin
          mon_e = exp_q.pop_front();
          check("event_kind_done", 64'(mon_e.is_done), 64'(1));
          $display("sweep_done pulse");
        end
      end
      mon_prev_valid = (result_valid === 1'b1);
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_adder_reset"}, 64'(adder_reset), 64'(1));
    check({tag, "_stop_b"}, 64'(stop_b), 64'(0));
    check({tag, "_counter_enable"}, 64'(counter_enable), 64'(0));
    check({tag, "_counter_load"}, 64'(counter_load), 64'(0));
    check({tag, "_ring_bit_b"}, 64'(ring_bit_b), 64'(8'hFF));
    check({tag, "_result_valid"}, 64'(result_valid), 64'(0));
    check({tag, "_result_count"}, 64'(result_count), 64'(0));
    check({tag, "_result_bit"}, 64'(result_bit), 64'(0));
    check({tag, "_result_timeout"}, 64'(result_timeout), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_sweep_done"}, 64'(sweep_done), 64'(0));
  endtask

  task automatic pulse_start(input logic [7:0] m, input logic [31:0] it);
    bit_mask         = m;
    integration_time = it;
    start            = 1'b1;
    @(negedge wb_clk_i);
    start            = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy === 1'b1) && k < budget) begin
      @(negedge wb_clk_i);
      k++;
    end
    check({name, "_pending_events"}, 64'(exp_q.size()), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
    repeat (2) @(negedge wb_clk_i);
  endtask

  initial begin : stimulus
    int k;
    reset_b          = 1'b0;
    start            = 1'b0;
    abort            = 1'b0;
    bit_mask         = '0;
    integration_time = '0;
    result_ready     = 1'b1;
    for (int i = 0; i < WIDTH; i++) bit_count[i] = '0;

    repeat (3) @(negedge wb_clk_i);
    check_reset_vals("por");
    reset_b = 1'b1;
    @(negedge wb_clk_i);

    // Two-bit sweep, mask 0x05.
    bit_count[0] = 32'h1234;
    bit_count[2] = 32'h2000;
    latency      = 100;
    push_res(3'd0, 32'h1234, 1'b0, 8'hFE);
    push_res(3'd2, 32'h2000, 1'b0, 8'hFB);
    push_done();
    pulse_start(8'h05, 32'd100);
    wait_drain(1000, "sweep_05");

    // Empty mask: immediate sweep_done, never busy.
    push_done();
    pulse_start(8'h00, 32'd100);
    check("empty_done_pulse", 64'(sweep_done), 64'(1));
    check("empty_busy0", 64'(busy), 64'(0));
    @(negedge wb_clk_i);
    check("empty_done_single", 64'(sweep_done), 64'(0));
    check("empty_busy1", 64'(busy), 64'(0));
    check("empty_valid", 64'(result_valid), 64'(0));
    wait_drain(10, "empty_mask");

    // Backpressure: result_ready low for 20 cycles in REPORT.
    bit_count[3] = 32'h0ABC;
    latency      = 10;
    result_ready = 1'b0;
    push_res(3'd3, 32'h0ABC, 1'b0, 8'hF7);
    push_done();
    pulse_start(8'h08, 32'd100);
    k = 0;
    while (result_valid !== 1'b1 && k < 200) begin
      @(negedge wb_clk_i);
      k++;
    end
    check("hold_valid_seen", 64'(result_valid), 64'(1));
    repeat (20) begin
      @(negedge wb_clk_i);
      check("hold_valid", 64'(result_valid), 64'(1));
      check("hold_count", 64'(result_count), 64'(32'h0ABC));
      check("hold_bit", 64'(result_bit), 64'(3));
      check("hold_stop_b", 64'(stop_b), 64'(0));
    end
    result_ready = 1'b1;
    wait_drain(20, "hold");

    // Abort in RUN of the second bit.
    bit_count[0] = 32'h0111;
    bit_count[2] = 32'h0222;
    latency      = 30;
    push_res(3'd0, 32'h0111, 1'b0, 8'hFE);
    pulse_start(8'h05, 32'd100);
    k = 0;
    while (!(stop_b === 1'b1 && ring_bit_b == 8'hFB) && k < 500) begin
      @(negedge wb_clk_i);
      k++;
    end
    check("abort_reached_bit2_run", 64'(stop_b), 64'(1));
    repeat (5) @(negedge wb_clk_i);
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_stop_b", 64'(stop_b), 64'(0));
    check("abort_counter_enable", 64'(counter_enable), 64'(0));
    check("abort_valid", 64'(result_valid), 64'(0));
    repeat (200) @(negedge wb_clk_i);
    check("abort_pending_events", 64'(exp_q.size()), 64'(0));

    // Reset during SETTLE, then a normal sweep.
    bit_count[1] = 32'h0F0F;
    latency      = 20;
    pulse_start(8'h02, 32'd100);
    check("select_ring", 64'(ring_bit_b), 64'(8'hFD));
    check("select_adder_reset", 64'(adder_reset), 64'(1));
    check("select_busy", 64'(busy), 64'(1));
    @(negedge wb_clk_i);
    check("settle_adder_reset", 64'(adder_reset), 64'(0));
    reset_b = 1'b0;
    @(negedge wb_clk_i);
    check_reset_vals("settle_rst");
    reset_b = 1'b1;
    repeat (20) @(negedge wb_clk_i);
    push_res(3'd1, 32'h0F0F, 1'b0, 8'hFD);
    push_done();
    pulse_start(8'h02, 32'd100);
    k = 1;
    while (counter_load !== 1'b1 && k < 50) begin
      @(negedge wb_clk_i);
      k++;
    end
    check("load_latency", 64'(k), 64'(6));
    wait_drain(500, "post_reset");

`ifdef SWEEP_TIMEOUT_EN
    // Watchdog: done never returned, integration_time 10 -> 26 RUN cycles.
    bit_count[0] = 32'h0055;
    latency      = 0;
    push_res(3'd0, 32'h0055, 1'b1, 8'hFE);
    push_done();
    pulse_start(8'h01, 32'd10);
    k = 0;
    while (counter_load !== 1'b1 && k < 50) begin
      @(negedge wb_clk_i);
      k++;
    end
    k = 0;
    while (k < 200) begin
      @(negedge wb_clk_i);
      if (stop_b !== 1'b1) break;
      k++;
    end
    check("timeout_run_cycles", 64'(k), 64'(26));
    wait_drain(100, "timeout");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
